// File: rtl/edge_arb_pkg.sv
// -----------------------------------------------------------------------------
// edge_arb_pkg
//   Shared definitions for the edge event arbiter.
//   - arb_state_t : two-state arbiter FSM encoding (IDLE = 0, OFFER = 1)
//   - clog2       : ceiling log2 used to size ids and counters, never below 1
// -----------------------------------------------------------------------------
package edge_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Returns ceil(log2(value)) with a floor of 1 so a width derived from it is
  // always legal, even for value <= 2.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// -----------------------------------------------------------------------------
// edge_chan
//   One channel of the edge event arbiter: registers the level input, detects
//   its rising edge and keeps a saturating count of events not yet consumed.
//
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous active-high reset
//   level    in   synchronous level input for this channel
//   acc      in   the arbiter's current offer for this channel is accepted
//   pending  out  registered, count is nonzero after this cycle's update
//   overflow out  registered one-cycle pulse, an edge was dropped at saturation
// -----------------------------------------------------------------------------
module edge_chan
  import edge_arb_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int CW       = clog2(MAX_PEND + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic level,
  input  logic acc,
  output logic pending,
  output logic overflow
);

  logic          lvl_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rise;
  logic          ovf_d;

  // An edge and an accept in the same cycle cancel: one event enters while
  // one leaves, so the count is unchanged and nothing is dropped even when
  // the counter sits at its ceiling.
  always_comb begin
    rise  = level & ~lvl_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (rise && !acc) begin
      if (cnt_q == CW'(MAX_PEND)) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (acc && !rise) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // pending is taken from the post-update count so it agrees with cnt_q in
  // every cycle; the arbiter relies on that to search without the raw counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lvl_q    <= 1'b0;
      cnt_q    <= '0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      lvl_q    <= level;
      cnt_q    <= cnt_d;
      pending  <= (cnt_d != '0);
      overflow <= ovf_d;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//   Multi-channel rising-edge event scheduler. Each channel counts its rising
//   edges (saturating); a round-robin arbiter offers one event at a time to a
//   single consumer.
//
//   Handshake: evt_valid/evt_id are registered. Once evt_valid is high, it
//   and evt_id stay unchanged until a clock edge at which evt_ready is high;
//   that edge is the transfer. The offer is never withdrawn or retargeted.
//   After a transfer evt_valid is low for at least one cycle.
//
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   level      in   [N]    synchronous level inputs
//   evt_valid  out         event offered to the consumer
//   evt_id     out  [IDW]  channel index of the offered event
//   evt_ready  in          consumer takes the offered event this cycle
//   pending    out  [N]    channel i has a nonzero count
//   overflow   out  [N]    one-cycle pulse, channel i dropped an edge
//   arb_state  out         arbiter FSM state (debug)
//   rr_ptr     out  [IDW]  round-robin search start (debug)
// -----------------------------------------------------------------------------
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_PEND = 3,
  localparam int IDW      = clog2(N),
  localparam int CW       = clog2(MAX_PEND + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   level,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow,
  output arb_state_t     arb_state,
  output logic [IDW-1:0] rr_ptr
);

  logic [N-1:0] acc;

  // ---------------------------------------------------------------------------
  // Per-channel edge detect and counters
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_chan
    assign acc[i] = evt_valid & evt_ready & (evt_id == IDW'(i));

    edge_chan #(
      .MAX_PEND (MAX_PEND),
      .CW       (CW)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .level    (level[i]),
      .acc      (acc[i]),
      .pending  (pending[i]),
      .overflow (overflow[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Circular search: first channel at or after rr_ptr with a pending event.
  // The index is reduced modulo N by a single conditional subtract, which is
  // enough because rr_ptr < N and the offset is < N.
  // ---------------------------------------------------------------------------
  logic           found;
  logic [IDW-1:0] sel;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr} + (IDW + 1)'(k);
      if (sum >= (IDW + 1)'(N)) begin
        sum = sum - (IDW + 1)'(N);
      end
      idx = sum[IDW-1:0];
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  arb_state_t     state_q;
  arb_state_t     state_d;
  logic           valid_d;
  logic [IDW-1:0] id_d;
  logic [IDW-1:0] rr_d;

  always_comb begin
    state_d = state_q;
    valid_d = evt_valid;
    id_d    = evt_id;
    rr_d    = rr_ptr;
    case (state_q)
      IDLE: begin
        if (found) begin
          valid_d = 1'b1;
          id_d    = sel;
          state_d = OFFER;
        end else begin
          valid_d = 1'b0;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          rr_d    = (evt_id == IDW'(N - 1)) ? '0 : evt_id + IDW'(1);
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      state_q   <= state_d;
      evt_valid <= valid_d;
      evt_id    <= id_d;
      rr_ptr    <= rr_d;
    end
  end

  assign arb_state = state_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_edge_event_arbiter
//   Self-checking bench for edge_event_arbiter (N = 4, MAX_PEND = 3).
//   Directed scenario tasks plus a randomized run compared cycle by cycle
//   against an event-level reference model (integer counts, a search pointer
//   and a queue of expected consumed ids).
// -----------------------------------------------------------------------------
module tb_edge_event_arbiter;
  import edge_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXP = 3;
  localparam int IDW  = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   level = '0;
  logic           evt_ready = 1'b0;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;
  arb_state_t     arb_state;
  logic [IDW-1:0] rr_ptr;

  always #5 clock = ~clock;

  edge_event_arbiter #(.N(N), .MAX_PEND(MAXP)) dut (
    .clock     (clock),
    .reset     (reset),
    .level     (level),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow),
    .arb_state (arb_state),
    .rr_ptr    (rr_ptr)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: events per channel as plain integers, one outstanding
  // offer, and a round-robin start pointer.
  // ---------------------------------------------------------------------------
  int             m_cnt[N];
  logic [N-1:0]   m_prev;
  logic [N-1:0]   m_ovf;
  bit             m_valid;
  int             m_id;
  int             m_ptr;
  logic [IDW-1:0] exp_q[$];
  logic [IDW-1:0] got_q[$];

  function automatic logic [N-1:0] m_pend();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_prev  = '0;
    m_ovf   = '0;
    m_valid = 1'b0;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  // One clock edge worth of behaviour, evaluated from the inputs in effect.
  task automatic model_update();
    int  pick;
    int  c;
    bit  e;
    bit  a;
    pick = -1;
    if (!m_valid) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (pick < 0 && m_cnt[c] > 0) pick = c;
      end
    end
    for (int i = 0; i < N; i++) begin
      e = level[i] && !m_prev[i];
      a = m_valid && evt_ready && (m_id == i);
      m_ovf[i] = 1'b0;
      if (e && !a) begin
        if (m_cnt[i] == MAXP) m_ovf[i] = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1;
      end else if (a && !e) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
    m_prev = level;
    if (m_valid) begin
      if (evt_ready) begin
        exp_q.push_back(IDW'(m_id));
        m_valid = 1'b0;
        m_ptr   = (m_id + 1) % N;
      end
    end else if (pick >= 0) begin
      m_valid = 1'b1;
      m_id    = pick;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change only at posedge + 1.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    level     = '0;
    evt_ready = 1'b0;
    reset     = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b expected 0", evt_valid);
    end
    checks++;
    if ({pending, overflow} !== '0) begin
      errors++; $display("FAIL reset_flags: got pend %b ovf %b expected 0", pending, overflow);
    end
    checks++;
    if (evt_id !== '0 || rr_ptr !== '0 || arb_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got id %0d ptr %0d st %0d expected 0", evt_id, rr_ptr, arb_state);
    end
    // A level already high when reset releases counts as one edge.
    reset = 1'b1;
    level = 4'b1000;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    tick();
    checks++;
    if (pending !== 4'b1000) begin
      errors++; $display("FAIL reset_level_high_pend: got %b expected 1000", pending);
    end
    evt_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (evt_valid && evt_ready) n++;
      tick();
    end
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL reset_level_high_events: got %0d expected 1", n);
    end
  endtask

  task automatic test_single_edge();
    do_reset();
    evt_ready = 1'b1;
    level[2]  = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b0 || pending !== 4'b0100) begin
      errors++; $display("FAIL single_first_cycle: got v %0b pend %b expected v 0 pend 0100", evt_valid, pending);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
      errors++; $display("FAIL single_offer: got v %0b id %0d expected v 1 id 2", evt_valid, evt_id);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0 || pending !== 4'b0000) begin
      errors++; $display("FAIL single_after_accept: got v %0b pend %b expected v 0 pend 0000", evt_valid, pending);
    end
    checks++;
    if (rr_ptr !== 2'd3) begin
      errors++; $display("FAIL single_rr_ptr: got %0d expected 3", rr_ptr);
    end
  endtask

  task automatic test_multi_order();
    int ids[$];
    int cyc[$];
    do_reset();
    evt_ready = 1'b1;
    level     = 4'b1011;
    for (int c = 0; c < 20; c++) begin
      if (evt_valid && evt_ready) begin
        ids.push_back(int'(evt_id));
        cyc.push_back(c);
      end
      tick();
    end
    checks++;
    if (ids.size() != 3) begin
      errors++; $display("FAIL multi_count: got %0d expected 3", ids.size());
    end else begin
      checks++;
      if (ids[0] != 0 || ids[1] != 1 || ids[2] != 3) begin
        errors++; $display("FAIL multi_order: got %0d %0d %0d expected 0 1 3", ids[0], ids[1], ids[2]);
      end
      checks++;
      if (cyc[1] - cyc[0] != 2 || cyc[2] - cyc[1] != 2) begin
        errors++; $display("FAIL multi_spacing: got %0d %0d expected 2 2", cyc[1] - cyc[0], cyc[2] - cyc[1]);
      end
    end
    checks++;
    if (pending !== 4'b0000) begin
      errors++; $display("FAIL multi_pending: got %b expected 0000", pending);
    end
  endtask

  task automatic test_saturate();
    int pulses;
    int pulse_edge;
    int n;
    do_reset();
    pulses     = 0;
    pulse_edge = -1;
    for (int e = 0; e < 4; e++) begin
      level[1] = 1'b1;
      tick();
      if (overflow[1]) begin
        pulses++;
        pulse_edge = e;
      end
      level[1] = 1'b0;
      tick();
      if (overflow[1]) pulses++;
    end
    checks++;
    if (pulses != 1 || pulse_edge != 3) begin
      errors++; $display("FAIL sat_overflow: got %0d pulses at edge %0d expected 1 at edge 3", pulses, pulse_edge);
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      errors++; $display("FAIL sat_held_offer: got v %0b id %0d expected v 1 id 1", evt_valid, evt_id);
    end
    evt_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (evt_valid && evt_ready && evt_id == 2'd1) n++;
      tick();
    end
    checks++;
    if (n != MAXP) begin
      errors++; $display("FAIL sat_drain: got %0d events expected %0d", n, MAXP);
    end
    checks++;
    if (pending !== 4'b0000) begin
      errors++; $display("FAIL sat_pending: got %b expected 0000", pending);
    end
  endtask

  task automatic test_edge_with_accept();
    do_reset();
    level[0] = 1'b1;
    tick();
    tick();
    level[0] = 1'b0;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      errors++; $display("FAIL ewa_offer: got v %0b id %0d expected v 1 id 0", evt_valid, evt_id);
    end
    level[0]  = 1'b1;
    evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b0 || pending[0] !== 1'b1 || overflow !== 4'b0000) begin
      errors++; $display("FAIL ewa_cancel: got v %0b pend %b ovf %b expected v 0 pend[0] 1 ovf 0", evt_valid, pending, overflow);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      errors++; $display("FAIL ewa_second: got v %0b id %0d expected v 1 id 0", evt_valid, evt_id);
    end
    tick();
    checks++;
    if (pending !== 4'b0000 || evt_valid !== 1'b0) begin
      errors++; $display("FAIL ewa_done: got pend %b v %0b expected 0000 0", pending, evt_valid);
    end
  endtask

  task automatic test_hold_offer();
    int bad;
    do_reset();
    level[1] = 1'b1;
    tick();
    tick();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) level[3] = 1'b1;
      tick();
      if (evt_valid !== 1'b1 || evt_id !== 2'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
    end
    evt_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      errors++; $display("FAIL hold_next: got v %0b id %0d expected v 1 id 3", evt_valid, evt_id);
    end
  endtask

  task automatic test_reset_mid_offer();
    int n;
    do_reset();
    level[0] = 1'b1;
    tick();
    level[0] = 1'b0;
    tick();
    level[0] = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      errors++; $display("FAIL rmo_offer: got v %0b id %0d expected v 1 id 0", evt_valid, evt_id);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (evt_valid !== 1'b0 || pending !== '0 || overflow !== '0) begin
      errors++; $display("FAIL rmo_async: got v %0b pend %b ovf %b expected all 0", evt_valid, pending, overflow);
    end
    level = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    evt_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (evt_valid) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL rmo_no_events: got %0d valid cycles expected 0", n);
    end
  endtask

  task automatic test_random();
    int thresh;
    int bad_v, bad_i, bad_p, bad_o;
    do_reset();
    exp_q.delete();
    got_q.delete();
    bad_v = 0; bad_i = 0; bad_p = 0; bad_o = 0;
    for (int c = 0; c < 600; c++) begin
      thresh = (c < 200) ? 8 : ((c < 400) ? 2 : 5);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) level[i] = ~level[i];
      end
      evt_ready = ($urandom_range(0, 9) < thresh);
      if (evt_valid && evt_ready) got_q.push_back(evt_id);
      tick();
      if (evt_valid !== m_valid) bad_v++;
      if (m_valid && evt_id !== IDW'(m_id)) bad_i++;
      if (pending !== m_pend()) bad_p++;
      if (overflow !== m_ovf) bad_o++;
    end
    level     = '0;
    evt_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (evt_valid && evt_ready) got_q.push_back(evt_id);
      tick();
    end
    checks++;
    if (bad_v != 0) begin
      errors++; $display("FAIL rand_valid: got %0d mismatching cycles expected 0", bad_v);
    end
    checks++;
    if (bad_i != 0) begin
      errors++; $display("FAIL rand_id: got %0d mismatching cycles expected 0", bad_i);
    end
    checks++;
    if (bad_p != 0) begin
      errors++; $display("FAIL rand_pending: got %0d mismatching cycles expected 0", bad_p);
    end
    checks++;
    if (bad_o != 0) begin
      errors++; $display("FAIL rand_overflow: got %0d mismatching cycles expected 0", bad_o);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_event_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      bad_i = 0;
      foreach (exp_q[k]) if (got_q[k] !== exp_q[k]) bad_i++;
      checks++;
      if (bad_i != 0) begin
        errors++; $display("FAIL rand_event_order: got %0d differing ids expected 0", bad_i);
      end
    end
    checks++;
    if (pending !== '0 || evt_valid !== 1'b0) begin
      errors++; $display("FAIL rand_drained: got pend %b v %0b expected 0 0", pending, evt_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_edge();
    test_multi_order();
    test_saturate();
    test_edge_with_accept();
    test_hold_offer();
    test_reset_mid_offer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
